// File: rtl/sfp_send_scheduler_if.sv
// rtl/sfp_send_scheduler_if.sv - send-packet command bundle between scheduler and both TSE send_packet blocks
interface sfp_send_scheduler_if #(
   parameter int ADDR_W = 25
);
   logic              cmd_send_1;
   logic              cmd_send_2;
   logic [ADDR_W-1:0] start_ram_addr_1;
   logic [ADDR_W-1:0] start_ram_addr_2;

   modport master (
      output cmd_send_1,
      output cmd_send_2,
      output start_ram_addr_1,
      output start_ram_addr_2
   );

   modport slave (
      input cmd_send_1,
      input cmd_send_2,
      input start_ram_addr_1,
      input start_ram_addr_2
   );
endinterface

// File: rtl/sfp_send_scheduler.sv
// rtl/sfp_send_scheduler.sv - serialises periodic and echo send requests of two channels onto one send grant
module sfp_send_scheduler #(
   parameter logic [31:0] PERIOD_1 = 32'd100_000_000,
   parameter logic [31:0] PERIOD_2 = 32'd117_000_000,
   parameter int          CMD_LEN  = 4,
   parameter int          GAP      = 16,
   parameter int          ADDR_W   = 25
) (
   input  logic              clk_50,
   input  logic              rst_n,
   input  logic              mac_inited,
   input  logic              rx_ready,
   input  logic              periodic_en_1,
   input  logic              periodic_en_2,
   input  logic              echo_en_1,
   input  logic              echo_en_2,
   input  logic              data_saved_1,
   input  logic              data_saved_2,
   input  logic [ADDR_W-1:0] cfg_addr_1,
   input  logic [ADDR_W-1:0] cfg_addr_2,
   sfp_send_scheduler_if.master send,
   output logic              busy,
   output logic [15:0]       sent_cnt_1,
   output logic [15:0]       sent_cnt_2,
   output logic [7:0]        overrun_cnt
);

   localparam logic [31:0] TMR_LAST_1 = (PERIOD_1 != 32'd0) ? PERIOD_1 - 32'd1 : 32'd0;
   localparam logic [31:0] TMR_LAST_2 = (PERIOD_2 != 32'd0) ? PERIOD_2 - 32'd1 : 32'd0;
   localparam logic [15:0] CMD_LAST   = 16'(CMD_LEN - 1);
   localparam logic [15:0] GAP_LAST   = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_GAP
   } state_t;

   state_t      state;
   logic [15:0] phase_cnt;
   logic [31:0] tmr_1;
   logic [31:0] tmr_2;
   logic        ds_q_1;
   logic        ds_q_2;
   logic        pend_1;
   logic        pend_2;
   logic        rr_ch2;
   logic        owner_2;

   logic        link_ok;
   logic        tmr_en_1;
   logic        tmr_en_2;
   logic        tmr_req_1;
   logic        tmr_req_2;
   logic        req_1;
   logic        req_2;
   logic        grant;
   logic        grant_2;
   logic        clr_1;
   logic        clr_2;
   logic        abort;
   logic        retry_1;
   logic        retry_2;
   logic        ovr_1;
   logic        ovr_2;
   logic [8:0]  ovr_sum;

   assign link_ok   = mac_inited & rx_ready;
   assign tmr_en_1  = link_ok & periodic_en_1 & (PERIOD_1 != 32'd0);
   assign tmr_en_2  = link_ok & periodic_en_2 & (PERIOD_2 != 32'd0);
   assign tmr_req_1 = tmr_en_1 & (tmr_1 == TMR_LAST_1);
   assign tmr_req_2 = tmr_en_2 & (tmr_2 == TMR_LAST_2);
   assign req_1     = tmr_req_1 | (data_saved_1 & ~ds_q_1 & echo_en_1 & link_ok);
   assign req_2     = tmr_req_2 | (data_saved_2 & ~ds_q_2 & echo_en_2 & link_ok);

   // rr_ch2 remembers the winner of the last contested grant; the other channel wins the next contest
   assign grant   = (state == ST_IDLE) & link_ok & (pend_1 | pend_2);
   assign grant_2 = pend_2 & (~pend_1 | ~rr_ch2);
   assign clr_1   = grant & ~grant_2;
   assign clr_2   = grant & grant_2;

   assign abort   = (state == ST_CMD) & ~link_ok;
   assign retry_1 = abort & ~owner_2;
   assign retry_2 = abort & owner_2;

   assign ovr_1   = req_1 & pend_1 & ~clr_1;
   assign ovr_2   = req_2 & pend_2 & ~clr_2;
   assign ovr_sum = {1'b0, overrun_cnt} + {8'd0, ovr_1} + {8'd0, ovr_2};

   assign busy    = (state != ST_IDLE);

   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         state                 <= ST_IDLE;
         phase_cnt             <= 16'd0;
         tmr_1                 <= 32'd0;
         tmr_2                 <= 32'd0;
         ds_q_1                <= 1'b0;
         ds_q_2                <= 1'b0;
         pend_1                <= 1'b0;
         pend_2                <= 1'b0;
         rr_ch2                <= 1'b1;
         owner_2               <= 1'b0;
         send.cmd_send_1       <= 1'b0;
         send.cmd_send_2       <= 1'b0;
         send.start_ram_addr_1 <= '0;
         send.start_ram_addr_2 <= '0;
         sent_cnt_1            <= 16'd0;
         sent_cnt_2            <= 16'd0;
         overrun_cnt           <= 8'd0;
      end else begin
         ds_q_1 <= data_saved_1;
         ds_q_2 <= data_saved_2;

         if (!tmr_en_1 || tmr_req_1) tmr_1 <= 32'd0;
         else                        tmr_1 <= tmr_1 + 32'd1;
         if (!tmr_en_2 || tmr_req_2) tmr_2 <= 32'd0;
         else                        tmr_2 <= tmr_2 + 32'd1;

         pend_1 <= (pend_1 & ~clr_1) | req_1 | retry_1;
         pend_2 <= (pend_2 & ~clr_2) | req_2 | retry_2;

         if (ovr_1 || ovr_2) overrun_cnt <= ovr_sum[8] ? 8'hFF : ovr_sum[7:0];

         case (state)
            ST_IDLE: begin
               if (grant) begin
                  state     <= ST_CMD;
                  phase_cnt <= 16'd0;
                  owner_2   <= grant_2;
                  if (pend_1 && pend_2) rr_ch2 <= grant_2;
                  if (grant_2) begin
                     send.cmd_send_2       <= 1'b1;
                     send.start_ram_addr_2 <= cfg_addr_2;
                  end else begin
                     send.cmd_send_1       <= 1'b1;
                     send.start_ram_addr_1 <= cfg_addr_1;
                  end
               end
            end
            ST_CMD: begin
               if (!link_ok) begin
                  send.cmd_send_1 <= 1'b0;
                  send.cmd_send_2 <= 1'b0;
                  state           <= ST_IDLE;
               end else if (phase_cnt == CMD_LAST) begin
                  send.cmd_send_1 <= 1'b0;
                  send.cmd_send_2 <= 1'b0;
                  if (owner_2) sent_cnt_2 <= sent_cnt_2 + 16'd1;
                  else         sent_cnt_1 <= sent_cnt_1 + 16'd1;
                  phase_cnt <= 16'd0;
                  state     <= (GAP == 0) ? ST_IDLE : ST_GAP;
               end else begin
                  phase_cnt <= phase_cnt + 16'd1;
               end
            end
            ST_GAP: begin
               if (phase_cnt == GAP_LAST) state <= ST_IDLE;
               else                       phase_cnt <= phase_cnt + 16'd1;
            end
            default: begin
               send.cmd_send_1 <= 1'b0;
               send.cmd_send_2 <= 1'b0;
               state           <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sfp_send_scheduler.md
Name: sfp_send_scheduler

Overview:
Sequences packet transmission on the two TSE MAC send-packet controls. It takes send requests from a per-channel periodic timer and a per-channel echo trigger (a rising edge on data_saved) and serialises them through one shared grant, so only one send command is ever active at a time. For each granted send it drives the cmd_send / start_ram_addr pair, enforces a minimum inter-command gap, and reports sent and overrun counts. It sits between the platform system_design and the top-level link status (mac_inited, rx_ready).

Parameters:
PERIOD_1, 32'd100_000_000, channel-1 periodic request interval in clk_50 cycles (0 disables timer 1)
PERIOD_2, 32'd117_000_000, channel-2 periodic request interval in clk_50 cycles (0 disables timer 2)
CMD_LEN, 4, cycles cmd_send_n is held high per send (>=1)
GAP, 16, idle cycles after cmd_send drops before the next grant (>=0)
ADDR_W, 25, start_ram_addr width

Ports:
clk_50  in  1  system clock (PLL 50 MHz domain)
rst_n  in  1  synchronous active-low reset
mac_inited  in  1  MAC configuration complete
rx_ready  in  1  transceiver reset controller rx ready
periodic_en_1  in  1  enable timer requests, channel 1
periodic_en_2  in  1  enable timer requests, channel 2
echo_en_1  in  1  enable data_saved echo requests, channel 1
echo_en_2  in  1  enable data_saved echo requests, channel 2
data_saved_1  in  1  receive-packet-1 saved flag (level)
data_saved_2  in  1  receive-packet-2 saved flag (level)
cfg_addr_1  in  ADDR_W  packet RAM start address, channel 1
cfg_addr_2  in  ADDR_W  packet RAM start address, channel 2
cmd_send_1  out  1  send command to send_packet_1
cmd_send_2  out  1  send command to send_packet_2
start_ram_addr_1  out  ADDR_W  start address to send_packet_1
start_ram_addr_2  out  ADDR_W  start address to send_packet_2
busy  out  1  high in CMD or GAP state
sent_cnt_1  out  16  completed sends, channel 1
sent_cnt_2  out  16  completed sends, channel 2
overrun_cnt  out  8  requests lost to an already-pending flag (both channels)

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0. FSM=IDLE, pending flags 0, timers 0, rr pointer favours channel 1, data_saved edge registers 0. Reset mid-CMD drops cmd_send on the next edge.
- link_ok = mac_inited & rx_ready, used unregistered.
- Timer n: counts only while link_ok & periodic_en_n & PERIOD_n!=0; otherwise held at 0. At count==PERIOD_n-1, raise request and wrap to 0. First request comes PERIOD_n cycles after enable.
- Echo n: data_saved_n registered; rising edge & echo_en_n & link_ok raises request.
- Request on channel n sets pending_n. If pending_n is already 1 and not being cleared by a grant in the same cycle, overrun_cnt +1, saturating at 255. Timer and echo requests in the same cycle count as one request (no overrun).
- FSM IDLE -> CMD: when link_ok and any pending. Grant goes to the single pending channel. If both are pending, grant goes to the channel opposite rr; rr is then set to the granted channel. On the grant edge: clear pending_n, latch cfg_addr_n into start_ram_addr_n, set cmd_send_n=1. Latency is 1 cycle from pending visible in IDLE to cmd_send high. Address stays stable until the next grant to the same channel.
- CMD: cmd_send_n high exactly CMD_LEN cycles. On its last cycle sent_cnt_n +1, wrapping at 16 bits. Then cmd_send_n=0 and FSM -> GAP, or -> IDLE if GAP==0.
- GAP: GAP cycles with both cmd_send low, then IDLE. A request during CMD/GAP only sets pending.
- cmd_send_1 and cmd_send_2 are never high together.
- link_ok drops in CMD: cmd_send_n=0 next edge, FSM -> IDLE, pending_n re-set to 1 (retry), no sent_cnt increment. link_ok drop in GAP: finish GAP normally. No grants while link_ok=0; pending flags are retained.
- busy = (FSM!=IDLE).

Test Plan:
- Reset/idle: rst_n=0 for 3 cycles, link_ok=0 -> all outputs 0, no cmd for 1000 cycles even with timers enabled.
- Periodic: PERIOD_1=200, CMD_LEN=4, GAP=16, link_ok=1, periodic_en_1=1, cfg_addr_1=1 -> cmd_send_1 high cycles 201..204 after enable, start_ram_addr_1=1, sent_cnt_1=1; repeats every 200 cycles.
- Echo: echo_en_2=1, cfg_addr_2=5, data_saved_2 goes 0->1 and holds -> exactly one cmd_send_2 pulse of 4 cycles, start 2 cycles after the edge, addr 5. Level held -> no further pulses.
- Arbitration: pending_1 and pending_2 set in the same cycle -> cmd_send_1 for 4 cycles, 16 gap cycles, then cmd_send_2. Next simultaneous pair -> channel 2 first. Never overlapping.
- Overrun: three data_saved_1 edges during one CMD+GAP window -> overrun_cnt=2, one extra send. 300 forced overruns -> overrun_cnt=255.
- Link drop: rx_ready=0 on 2nd cycle of CMD -> cmd_send low next cycle, sent_cnt unchanged. rx_ready=1 again -> same channel re-sent with 4-cycle pulse, sent_cnt +1.
